imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory.
- Consumes a byte stream from a UART receiver, frames it, assembles little-endian 32-bit instructions and issues word-aligned writes on the imem write port.
- Holds the CPU in reset while a load is in flight.
- Sits between the serial receiver and the writable instruction RAM (65 words, word-addressed by address bits [31:2]).

Parameters:
- MAX_WORDS, 65, maximum number of instruction words accepted in one frame (RAM depth).
- TIMEOUT_CYC, 1000000, idle clock cycles allowed between bytes inside a frame before the frame is aborted.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  one-cycle strobe: rx_data holds a new byte. No backpressure.
- rx_data  input  8  received byte.
- we  output  1  imem write enable, one-cycle pulse per word.
- wa  output  32  imem byte address of the write; always word aligned (wa[1:0]=0).
- wd  output  32  imem write data.
- cpu_reset  output  1  holds the processor in reset while a load is incomplete.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the last word has been written.
- err  output  1  sticky frame error flag.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: state=IDLE, we=0, wa=0, wd=0, cpu_reset=0, busy=0, done=0, err=0. All counters and the partial-word register are 0.
- Reset asserted mid-frame aborts immediately. The partial word is discarded and no write is issued.
- Frame format: SYNC_BYTE, then COUNT_LO, COUNT_HI (16-bit word count N, little-endian), then 4*N data bytes. Each word is little-endian: the first byte goes to bits [7:0].
- FSM states and transitions:
  - IDLE: bytes other than SYNC_BYTE are ignored. On SYNC_BYTE -> CNT0; set cpu_reset=1, clear err.
  - CNT0: latch COUNT_LO -> CNT1.
  - CNT1: latch COUNT_HI, forming N.
    - If N==0 or N>MAX_WORDS -> IDLE with err=1; cpu_reset stays 1.
    - Otherwise -> DATA, with word index=0 and byte index=0.
  - DATA: shift each byte into position byte_idx.
    - On the 4th byte: on the next clock, we=1, wa=index<<2, wd=assembled word, index increments, byte_idx wraps to 0.
    - If that word was index N-1 -> IDLE; in that same write cycle done=1 and cpu_reset=0.
- Write latency: we rises on the first clock edge after the 4th byte's rx_valid cycle. wa and wd are valid only while we=1 and hold their last values otherwise.
- A new byte arriving in the cycle that we=1 is accepted normally. Bytes may arrive on back-to-back cycles with no loss.
- Timeout:
  - In CNT0, CNT1 or DATA, a counter counts cycles since the last rx_valid and clears on every rx_valid.
  - When it reaches TIMEOUT_CYC -> IDLE, err=1. The partial word is dropped; already-written words remain.
  - cpu_reset stays 1, because memory holds a partial program.
- err and cpu_reset are released only by a later fully successful frame (cpu_reset falls with done) or by reset. A new SYNC_BYTE clears err.
- SYNC_BYTE value inside CNT0, CNT1 or DATA is treated as ordinary data. There is no resync mid-frame.
- rx_valid and timeout expiry in the same cycle: the byte wins and the counter clears.
- Counters:
  - Word index is 16 bits.
  - wa = {14'b0, index, 2'b00}.
  - Timeout counter width is ceil(log2(TIMEOUT_CYC+1)).
- busy = (state != IDLE).

Test Plan:
- Normal load: A5 02 00 0F 00 4F E0 0F 10 4F E0 -> we pulses twice: wa=0x0/wd=0xE04F000F, then wa=0x4/wd=0xE04F100F. done pulses with the 2nd write. cpu_reset is 1 from the cycle after A5 until done. busy=0 afterwards.
- Garbage before sync, back-to-back bytes: 00 FF A5 01 00 01 00 A0 E3 on consecutive cycles -> exactly one write, wa=0, wd=0xE3A00001. Leading bytes are ignored.
- Bad count: A5 00 00 -> no write, err=1, cpu_reset=1. Then A5 42 00 (N=66) -> err=1. A following valid 1-word frame clears err and drops cpu_reset at done.
- Timeout (TIMEOUT_CYC=16 in the bench): A5 01 00 11 22, then silence -> 16 cycles later state=IDLE, err=1, cpu_reset=1, no write issued.
- Reset mid-frame: A5 01 00 11 22 33, then assert reset for 1 cycle, then byte 44 -> no write. All outputs are at reset values, and byte 44 is ignored in IDLE.
- Max frame: N=65, 260 bytes -> 65 writes. The last write has wa=0x100. done coincides with the 65th we.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte stream from the UART receiver plus the instruction-memory write port.
// The master side is the loader; the slave side is the environment.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;

  modport master (
    input  rx_valid,
    input  rx_data,
    output we,
    output wa,
    output wd
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  we,
    input  wa,
    input  wd
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: frames a UART byte stream into little-endian
// words and writes them to imem, holding the CPU in reset while a load is incomplete.
module imem_loader #(
  parameter int unsigned MAX_WORDS   = 65,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StCnt0, StCnt1, StData} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_lo_q;
  logic [15:0]     n_q;
  logic [15:0]     idx_q;
  logic [1:0]      bidx_q;
  logic [23:0]     part_q;
  logic [TmoW-1:0] tmo_q;
  logic            we_q, done_q, err_q, cpu_reset_q;
  logic [31:0]     wa_q, wd_q;

  logic [15:0] count;
  logic        count_bad;
  logic        tmo_expire;
  logic        sync_hit, bad_cnt, word_done, last_word;

  assign count     = {bus.rx_data, cnt_lo_q};
  assign count_bad = (count == 16'd0) || (32'(count) > MAX_WORDS);
  // Expiry fires on the edge where the idle count would reach TIMEOUT_CYC; a byte wins.
  assign tmo_expire = (state_q != StIdle) && !bus.rx_valid && (tmo_q == TmoLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sync_hit  = 1'b0;
    bad_cnt   = 1'b0;
    word_done = 1'b0;
    last_word = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
          state_d  = StCnt0;
          sync_hit = 1'b1;
        end
      end
      StCnt0: begin
        if (bus.rx_valid) state_d = StCnt1;
      end
      StCnt1: begin
        if (bus.rx_valid) begin
          if (count_bad) begin
            state_d = StIdle;
            bad_cnt = 1'b1;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (bus.rx_valid && (bidx_q == 2'd3)) begin
          word_done = 1'b1;
          if (idx_q + 16'd1 == n_q) begin
            last_word = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (tmo_expire) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_lo_q    <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      bidx_q      <= '0;
      part_q      <= '0;
      tmo_q       <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b0;
      wa_q        <= '0;
      wd_q        <= '0;
    end else begin
      we_q   <= word_done;
      done_q <= last_word;
      tmo_q  <= (state_d == StIdle || bus.rx_valid) ? '0 : tmo_q + 1'b1;

      if (state_q == StCnt0 && bus.rx_valid) cnt_lo_q <= bus.rx_data;

      if (state_q == StCnt1 && bus.rx_valid) begin
        n_q    <= count;
        idx_q  <= '0;
        bidx_q <= '0;
        part_q <= '0;
      end

      if (word_done) begin
        wa_q   <= {14'b0, idx_q, 2'b00};
        wd_q   <= {bus.rx_data, part_q};
        idx_q  <= idx_q + 16'd1;
        bidx_q <= '0;
      end else if (state_q == StData && bus.rx_valid) begin
        unique case (bidx_q)
          2'd0:    part_q[7:0]   <= bus.rx_data;
          2'd1:    part_q[15:8]  <= bus.rx_data;
          default: part_q[23:16] <= bus.rx_data;
        endcase
        bidx_q <= bidx_q + 2'd1;
      end

      if (sync_hit) begin
        err_q       <= 1'b0;
        cpu_reset_q <= 1'b1;
      end else if (bad_cnt || tmo_expire) begin
        err_q <= 1'b1;
      end
      if (last_word) cpu_reset_q <= 1'b0;
    end
  end

  assign bus.we = we_q;
  assign bus.wa = wa_q;
  assign bus.wd = wd_q;

  always_comb begin
    busy      = (state_q != StIdle);
    done      = done_q;
    err       = err_q;
    cpu_reset = cpu_reset_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are generated at word level and the
// expected imem writes are compared against writes observed on the bus.
module tb_imem_loader;

  localparam int unsigned TMO = 16;

  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
    logic        done;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic cpu_reset, busy, done, err;

  imem_loader_if bus ();

  imem_loader #(
    .MAX_WORDS  (65),
    .TIMEOUT_CYC(TMO),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int stray_done = 0;
  wr_t obs_q[$];
  wr_t exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.we) obs_q.push_back('{wa: bus.wa, wd: bus.wd, done: done});
      else if (done) stray_done++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic send_gap(input logic [7:0] b, input int maxgap);
    send(b);
    idle(int'($urandom_range(maxgap, 0)));
  endtask

  // Count plus data bytes; the reference writes are word index * 4, done on the last.
  task automatic send_body(input int n, input int maxgap, input bit sync_in_data);
    logic [15:0] cnt;
    logic [31:0] w;
    cnt = 16'(n);
    send_gap(cnt[7:0], maxgap);
    send_gap(cnt[15:8], maxgap);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (sync_in_data && i == 0) w[15:8] = 8'hA5;
      exp_q.push_back('{wa: 32'(i * 4), wd: w, done: (i == n - 1)});
      for (int b = 0; b < 4; b++) send_gap(w[8*b +: 8], maxgap);
    end
  endtask

  task automatic send_frame(input int n, input int maxgap, input bit sync_in_data);
    send_gap(8'hA5, maxgap);
    send_body(n, maxgap, sync_in_data);
  endtask

  task automatic compare(input string tag);
    int m;
    idle(2);
    check_eq({tag, ".nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check_eq($sformatf("%s.wa[%0d]", tag, i), obs_q[i].wa, exp_q[i].wa);
      check_eq($sformatf("%s.wd[%0d]", tag, i), obs_q[i].wd, exp_q[i].wd);
      check_eq($sformatf("%s.done[%0d]", tag, i), 32'(obs_q[i].done), 32'(exp_q[i].done));
    end
    check_eq({tag, ".stray_done"}, 32'(stray_done), 32'd0);
    obs_q.delete();
    exp_q.delete();
    stray_done = 0;
  endtask

  task automatic check_flags(input string tag, input logic b, input logic e, input logic c);
    check_eq({tag, ".busy"}, 32'(busy), 32'(b));
    check_eq({tag, ".err"}, 32'(err), 32'(e));
    check_eq({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(c));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] normal [11];
    logic [7:0] garbage [9];
    logic [7:0] g;
    logic [31:0] w;

    normal  = '{8'hA5, 8'h02, 8'h00, 8'h0F, 8'h00, 8'h4F, 8'hE0, 8'h0F, 8'h10, 8'h4F, 8'hE0};
    garbage = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'hA0, 8'hE3};

    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle(3);
    check_eq("rst.we", 32'(bus.we), 32'd0);
    check_eq("rst.wa", bus.wa, 32'd0);
    check_eq("rst.wd", bus.wd, 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(1);

    // Normal two-word load.
    send(normal[0]);
    check_flags("normal.sync", 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 11; i++) send_gap(normal[i], 2);
    exp_q.push_back('{wa: 32'h0, wd: 32'hE04F000F, done: 1'b0});
    exp_q.push_back('{wa: 32'h4, wd: 32'hE04F100F, done: 1'b1});
    compare("normal");
    check_flags("normal.end", 1'b0, 1'b0, 1'b0);

    // Garbage before sync, bytes back-to-back.
    for (int i = 0; i < 9; i++) send(garbage[i]);
    exp_q.push_back('{wa: 32'h0, wd: 32'hE3A00001, done: 1'b1});
    compare("b2b");
    check_flags("b2b.end", 1'b0, 1'b0, 1'b0);

    // Bad counts, then a good frame clears err and releases the CPU.
    send(8'hA5); send(8'h00); send(8'h00);
    compare("cnt0");
    check_flags("cnt0", 1'b0, 1'b1, 1'b1);
    send(8'hA5); send(8'h42); send(8'h00);
    compare("cnt66");
    check_flags("cnt66", 1'b0, 1'b1, 1'b1);
    send(8'hA5);
    check_flags("recover.sync", 1'b1, 1'b0, 1'b1);
    send_body(1, 1, 1'b0);
    compare("recover");
    check_flags("recover.end", 1'b0, 1'b0, 1'b0);

    // Timeout mid-word: expires on the TMO-th silent cycle.
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    idle(TMO - 1);
    check_flags("tmo.before", 1'b1, 1'b0, 1'b1);
    idle(1);
    check_flags("tmo.after", 1'b0, 1'b1, 1'b1);
    compare("tmo");

    // A byte arriving on the expiry cycle keeps the frame alive.
    send(8'hA5); send(8'h01); send(8'h00);
    idle(TMO - 1);
    w = $urandom;
    exp_q.push_back('{wa: 32'h0, wd: w, done: 1'b1});
    for (int b = 0; b < 4; b++) send(w[8*b +: 8]);
    compare("tmo.edge");
    check_flags("tmo.edge", 1'b0, 1'b0, 1'b0);

    // Reset mid-frame drops the partial word; a following stray byte is ignored.
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h33);
    reset = 1'b1;
    #1;
    check_eq("rstmid.async_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_flags("rstmid", 1'b0, 1'b0, 1'b0);
    send(8'h44);
    compare("rstmid");
    check_flags("rstmid.after", 1'b0, 1'b0, 1'b0);
    check_eq("rstmid.wa", bus.wa, 32'd0);
    check_eq("rstmid.wd", bus.wd, 32'd0);

    // Largest legal frame.
    send_frame(65, 1, 1'b1);
    compare("max");
    check_flags("max.end", 1'b0, 1'b0, 1'b0);
    check_eq("max.last_wa", bus.wa, 32'h100);

    // Random frames with leading garbage and random spacing.
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(3, 0)) begin
        do g = 8'($urandom); while (g == 8'hA5);
        send_gap(g, 2);
      end
      send_frame(int'($urandom_range(6, 1)), int'($urandom_range(3, 0)), it[0]);
      compare($sformatf("rand%0d", it));
      check_flags($sformatf("rand%0d", it), 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
